// File: rtl/ecat_fifo_mem_bridge_pkg.sv
// Shared types and sizing for the datagram-handler to ESC-memory bridge.
package ecat_fifo_mem_bridge_pkg;

    localparam int unsigned WBUF_DEPTH = 64;
    localparam int unsigned WBUF_AW    = 6;
    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned ENTRY_W    = ADDR_W + DATA_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_RD,
        ST_RD_DATA,
        ST_DRAIN
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wbuf_entry_t;

endpackage

// File: rtl/ecat_wbuf_fifo.sv
// Circular staging buffer for one frame's write bytes; exposes head and head+1
// so the drain can present the next entry on the cycle after a grant.
module ecat_wbuf_fifo
    import ecat_fifo_mem_bridge_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_push,
    input  wbuf_entry_t        i_din,
    input  logic               i_pop,
    input  logic               i_flush,
    output wbuf_entry_t        o_head_c,
    output wbuf_entry_t        o_next_c,
    output logic [WBUF_AW:0]   o_level,
    output logic               o_full_c,
    output logic               o_empty_c
);

    logic [ENTRY_W-1:0] r_mem [WBUF_DEPTH];
    logic [WBUF_AW-1:0] r_wr_ptr;
    logic [WBUF_AW-1:0] r_rd_ptr;
    logic [WBUF_AW:0]   r_level;
    logic               w_push_ok;
    logic               w_pop_ok;

    assign o_full_c  = (r_level == (WBUF_AW+1)'(WBUF_DEPTH));
    assign o_empty_c = (r_level == '0);
    assign w_push_ok = i_push & ~o_full_c;
    assign w_pop_ok  = i_pop & ~o_empty_c;
    assign o_head_c  = wbuf_entry_t'(r_mem[r_rd_ptr]);
    assign o_next_c  = wbuf_entry_t'(r_mem[r_rd_ptr + WBUF_AW'(1)]);
    assign o_level   = r_level;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= ENTRY_W'(i_din);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + WBUF_AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + WBUF_AW'(1);
            r_level <= r_level + (WBUF_AW+1)'(w_push_ok) - (WBUF_AW+1)'(w_pop_ok);
        end
    end

endmodule

// File: rtl/ecat_fifo_mem_bridge.sv
// Serves datagram-handler byte reads straight from ESC memory and stages writes
// until the frame's FCS verdict, then drains them through the memory arbiter.
module ecat_fifo_mem_bridge
    import ecat_fifo_mem_bridge_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fifo_sof,
    input  logic                fifo_eof,
    input  logic                fifo_valid,
    input  logic                fifo_read,
    input  logic [15:0]         fifo_addr,
    input  logic [7:0]          fifo_wdata,
    output logic [7:0]          fifo_rdata,
    output logic                fifo_ready,
    input  logic                frame_ok,
    input  logic                frame_err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [15:0]         mem_addr,
    output logic [7:0]          mem_wdata,
    input  logic                mem_gnt,
    input  logic [7:0]          mem_rdata,
    output logic [WBUF_AW:0]    wbuf_level,
    output logic                wbuf_ovf,
    output logic                commit_done
);

    state_t      r_state, w_state_nxt;
    logic        r_fifo_ready, w_fifo_ready_nxt;
    logic [7:0]  r_fifo_rdata, w_fifo_rdata_nxt;
    logic        r_mem_req, w_mem_req_nxt;
    logic        r_mem_we, w_mem_we_nxt;
    logic [15:0] r_mem_addr, w_mem_addr_nxt;
    logic [7:0]  r_mem_wdata, w_mem_wdata_nxt;
    logic        r_ovf, w_ovf_nxt;
    logic        r_commit, w_commit_nxt;
    logic        r_ok_pend, w_ok_pend_nxt;
    logic        r_err_pend, w_err_pend_nxt;
    logic        r_pend_vld, r_pend_read;
    logic [15:0] r_pend_addr;
    logic [7:0]  r_pend_wdata;

    logic        w_acc_vld, w_acc_read, w_pend_vld_nxt;
    logic [15:0] w_acc_addr;
    logic [7:0]  w_acc_wdata;
    logic        w_ok, w_err, w_serve, w_take;
    logic        w_push, w_pop, w_flush, w_full, w_empty;
    wbuf_entry_t w_din, w_head, w_next;
    logic        w_unused_frame_marks;

    // Frame boundaries are implied by frame_ok/frame_err, so sof/eof carry no state here.
    assign w_unused_frame_marks = fifo_sof ^ fifo_eof;

    // Access source: the pending slot if occupied, else the live strobe.
    assign w_acc_vld   = r_pend_vld | fifo_valid;
    assign w_acc_read  = r_pend_vld ? r_pend_read  : fifo_read;
    assign w_acc_addr  = r_pend_vld ? r_pend_addr  : fifo_addr;
    assign w_acc_wdata = r_pend_vld ? r_pend_wdata : fifo_wdata;
    assign w_pend_vld_nxt = fifo_valid ? ~(w_take & ~r_pend_vld) : (r_pend_vld & ~w_take);
    assign w_din = {w_acc_addr, w_acc_wdata};
    assign w_ok  = frame_ok  | r_ok_pend;
    assign w_err = frame_err | r_err_pend;

    ecat_wbuf_fifo u_wbuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_push),
        .i_din     (w_din),
        .i_pop     (w_pop),
        .i_flush   (w_flush),
        .o_head_c  (w_head),
        .o_next_c  (w_next),
        .o_level   (wbuf_level),
        .o_full_c  (w_full),
        .o_empty_c (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_fifo_ready <= 1'b0;
            r_fifo_rdata <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_ovf        <= 1'b0;
            r_commit     <= 1'b0;
            r_ok_pend    <= 1'b0;
            r_err_pend   <= 1'b0;
            r_pend_vld   <= 1'b0;
            r_pend_read  <= 1'b0;
            r_pend_addr  <= '0;
            r_pend_wdata <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_fifo_ready <= w_fifo_ready_nxt;
            r_fifo_rdata <= w_fifo_rdata_nxt;
            r_mem_req    <= w_mem_req_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_ovf        <= w_ovf_nxt;
            r_commit     <= w_commit_nxt;
            r_ok_pend    <= w_ok_pend_nxt;
            r_err_pend   <= w_err_pend_nxt;
            r_pend_vld   <= w_pend_vld_nxt;
            if (fifo_valid) begin
                r_pend_read  <= fifo_read;
                r_pend_addr  <= fifo_addr;
                r_pend_wdata <= fifo_wdata;
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_fifo_ready_nxt = 1'b0;
        w_fifo_rdata_nxt = r_fifo_rdata;
        w_mem_req_nxt    = r_mem_req;
        w_mem_we_nxt     = r_mem_we;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_ovf_nxt        = r_ovf;
        w_commit_nxt     = 1'b0;
        w_ok_pend_nxt    = r_ok_pend;
        w_err_pend_nxt   = r_err_pend;
        w_serve          = 1'b0;
        w_take           = 1'b0;
        w_push           = 1'b0;
        w_pop            = 1'b0;
        w_flush          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_ok_pend_nxt  = 1'b0;
                w_err_pend_nxt = 1'b0;
                if (w_acc_vld) begin
                    w_ovf_nxt = 1'b0;
                    w_serve   = 1'b1;
                end
            end
            ST_ACTIVE: begin
                // Overflowed frames cannot be committed partially, so ok degrades to err.
                if (w_err || (w_ok && r_ovf)) begin
                    w_flush        = 1'b1;
                    w_ok_pend_nxt  = 1'b0;
                    w_err_pend_nxt = 1'b0;
                    w_state_nxt    = ST_IDLE;
                end else if (w_ok) begin
                    w_ok_pend_nxt = 1'b0;
                    if (w_empty) begin
                        w_commit_nxt = 1'b1;
                        w_state_nxt  = ST_IDLE;
                    end else begin
                        w_mem_req_nxt   = 1'b1;
                        w_mem_we_nxt    = 1'b1;
                        w_mem_addr_nxt  = w_head.addr;
                        w_mem_wdata_nxt = w_head.data;
                        w_state_nxt     = ST_DRAIN;
                    end
                end else if (w_acc_vld) begin
                    w_serve = 1'b1;
                end
            end
            ST_RD: begin
                if (frame_ok)  w_ok_pend_nxt  = 1'b1;
                if (frame_err) w_err_pend_nxt = 1'b1;
                if (mem_gnt) begin
                    w_mem_req_nxt = 1'b0;
                    w_state_nxt   = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (frame_ok)  w_ok_pend_nxt  = 1'b1;
                if (frame_err) w_err_pend_nxt = 1'b1;
                w_fifo_rdata_nxt = mem_rdata;
                w_fifo_ready_nxt = 1'b1;
                w_state_nxt      = ST_ACTIVE;
            end
            ST_DRAIN: begin
                if (mem_gnt) begin
                    w_pop = 1'b1;
                    if (wbuf_level == (WBUF_AW+1)'(1)) begin
                        w_mem_req_nxt = 1'b0;
                        w_mem_we_nxt  = 1'b0;
                        w_commit_nxt  = 1'b1;
                        w_state_nxt   = ST_IDLE;
                    end else begin
                        w_mem_addr_nxt  = w_next.addr;
                        w_mem_wdata_nxt = w_next.data;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Accept one access: reads go to the arbiter, writes are staged or dropped.
        if (w_serve) begin
            w_take = 1'b1;
            if (w_acc_read) begin
                w_mem_req_nxt  = 1'b1;
                w_mem_we_nxt   = 1'b0;
                w_mem_addr_nxt = w_acc_addr;
                w_state_nxt    = ST_RD;
            end else begin
                w_fifo_ready_nxt = 1'b1;
                w_state_nxt      = ST_ACTIVE;
                if (w_full) w_ovf_nxt = 1'b1;
                else        w_push    = 1'b1;
            end
        end
    end

    assign fifo_ready  = r_fifo_ready;
    assign fifo_rdata  = r_fifo_rdata;
    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign wbuf_ovf    = r_ovf;
    assign commit_done = r_commit;

endmodule

// File: tb/tb_ecat_fifo_mem_bridge.sv
// Directed bench for ecat_fifo_mem_bridge with an arbiter/memory model and
// scoreboards for memory writes and fifo responses.
module tb_ecat_fifo_mem_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fifo_sof, fifo_eof, fifo_valid, fifo_read;
    logic [15:0] fifo_addr;
    logic [7:0]  fifo_wdata;
    logic [7:0]  fifo_rdata;
    logic        fifo_ready;
    logic        frame_ok, frame_err;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_gnt = 1'b0;
    logic [7:0]  mem_rdata = 8'hE7;
    logic [6:0]  wbuf_level;
    logic        wbuf_ovf;
    logic        commit_done;

    always #5 clk = ~clk;

    ecat_fifo_mem_bridge dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fifo_sof    (fifo_sof),
        .fifo_eof    (fifo_eof),
        .fifo_valid  (fifo_valid),
        .fifo_read   (fifo_read),
        .fifo_addr   (fifo_addr),
        .fifo_wdata  (fifo_wdata),
        .fifo_rdata  (fifo_rdata),
        .fifo_ready  (fifo_ready),
        .frame_ok    (frame_ok),
        .frame_err   (frame_err),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_gnt     (mem_gnt),
        .mem_rdata   (mem_rdata),
        .wbuf_level  (wbuf_level),
        .wbuf_ovf    (wbuf_ovf),
        .commit_done (commit_done)
    );

    typedef struct {
        logic       rd;
        logic [7:0] data;
        logic [15:0] addr;
    } rsp_t;

    rsp_t        exp_rsp[$];
    logic [23:0] exp_wr[$];
    logic [7:0]  mem_model [0:65535];

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    int gnt_delay = 1;
    int req_cyc = 0;
    int wr_seen = 0;
    int commit_cnt = 0;
    int last_wgnt_cyc = 0;
    int rd_gnt_cyc = 0;
    bit wr_since_commit = 1'b0;
    logic [15:0] exp_rd_addr = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory returns read data only in the cycle after a read grant.
    always @(posedge clk)
        mem_rdata <= (mem_req && mem_gnt && !mem_we) ? mem_model[mem_addr] : 8'hE7;

    // Arbiter model plus output monitors, all sampled mid-cycle.
    always @(negedge clk) begin
        logic [23:0] w;
        rsp_t r;
        if (mem_req) req_cyc++;
        else         req_cyc = 0;
        mem_gnt = mem_req && (req_cyc >= gnt_delay);
        if (mem_gnt && mem_we) begin
            wr_seen++;
            chk("wr_expected", 32'(exp_wr.size() != 0), 1);
            if (exp_wr.size() != 0) begin
                w = exp_wr.pop_front();
                chk("wr_addr_data", 32'({mem_addr, mem_wdata}), 32'(w));
            end
            mem_model[mem_addr] = mem_wdata;
            last_wgnt_cyc = cyc;
            wr_since_commit = 1'b1;
        end else if (mem_gnt) begin
            rd_gnt_cyc = cyc;
            chk("rd_addr", 32'(mem_addr), 32'(exp_rd_addr));
            chk("rd_after_drain", 32'(exp_wr.size()), 0);
        end
        if (fifo_ready) begin
            chk("rsp_expected", 32'(exp_rsp.size() != 0), 1);
            if (exp_rsp.size() != 0) begin
                r = exp_rsp.pop_front();
                if (r.rd) begin
                    chk("rd_data", 32'(fifo_rdata), 32'(r.data));
                    chk("rd_ready_after_gnt", 32'(cyc - rd_gnt_cyc), 2);
                end
            end
        end
        if (commit_done) begin
            commit_cnt++;
            chk("commit_queue_empty", 32'(exp_wr.size()), 0);
            if (wr_since_commit)
                chk("commit_after_last_gnt", 32'(cyc - last_wgnt_cyc), 1);
            wr_since_commit = 1'b0;
        end
    end

    task automatic access(input logic rd, input logic sof, input logic eof,
                          input logic [15:0] addr, input logic [7:0] val,
                          input logic commit, output int lat);
        rsp_t r;
        @(negedge clk);
        fifo_valid = 1'b1;
        fifo_read  = rd;
        fifo_sof   = sof;
        fifo_eof   = eof;
        fifo_addr  = addr;
        fifo_wdata = rd ? 8'h00 : val;
        r.rd = rd;
        r.data = val;
        r.addr = addr;
        exp_rsp.push_back(r);
        if (rd) exp_rd_addr = addr;
        else if (commit) exp_wr.push_back({addr, val});
        lat = 0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            fifo_valid = 1'b0;
            fifo_sof   = 1'b0;
            fifo_eof   = 1'b0;
            if (fifo_ready) begin
                lat = k;
                break;
            end
        end
        chk("ready_seen", 32'(lat != 0), 1);
    endtask

    task automatic pulse(input logic ok, input logic err);
        @(negedge clk);
        frame_ok  = ok;
        frame_err = err;
        @(negedge clk);
        frame_ok  = 1'b0;
        frame_err = 1'b0;
    endtask

    task automatic wait_commit(input int target);
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            #1;
            if (commit_cnt == target) break;
        end
        chk("commit_count", 32'(commit_cnt), 32'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int lat;
        for (int i = 0; i < 65536; i++) mem_model[i] = 8'(i ^ (i >> 8));
        rst_n = 1'b0;
        fifo_sof = 0; fifo_eof = 0; fifo_valid = 0; fifo_read = 0;
        fifo_addr = '0; fifo_wdata = '0; frame_ok = 0; frame_err = 0;
        repeat (3) @(negedge clk);
        chk("rst_fifo_ready", 32'(fifo_ready), 0);
        chk("rst_fifo_rdata", 32'(fifo_rdata), 0);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_level", 32'(wbuf_level), 0);
        chk("rst_ovf", 32'(wbuf_ovf), 0);
        chk("rst_commit", 32'(commit_done), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Three staged writes committed on a good frame.
        access(0, 1, 0, 16'h1000, 8'hAA, 1, lat); chk("w1_lat", 32'(lat), 1);
        access(0, 0, 0, 16'h1001, 8'hBB, 1, lat); chk("w2_lat", 32'(lat), 1);
        access(0, 0, 1, 16'h1002, 8'hCC, 1, lat); chk("w3_lat", 32'(lat), 1);
        chk("level_3", 32'(wbuf_level), 3);
        chk("no_wr_before_ok", 32'(wr_seen), 0);
        pulse(1, 0);
        wait_commit(1);
        chk("wr_count_3", 32'(wr_seen), 3);
        chk("level_after_drain", 32'(wbuf_level), 0);

        // Bad frame discards its writes.
        access(0, 1, 0, 16'h1100, 8'h01, 0, lat);
        access(0, 0, 1, 16'h1101, 8'h02, 0, lat);
        chk("level_2", 32'(wbuf_level), 2);
        pulse(0, 1);
        repeat (6) @(negedge clk);
        chk("err_level", 32'(wbuf_level), 0);
        chk("err_no_wr", 32'(wr_seen), 3);
        chk("err_no_commit", 32'(commit_cnt), 1);

        // Slow grant on a read, then an empty commit.
        mem_model[16'h0130] = 8'h5A;
        gnt_delay = 5;
        access(1, 1, 1, 16'h0130, 8'h5A, 0, lat);
        chk("slow_rd_lat", 32'(lat), 7);
        gnt_delay = 1;
        pulse(1, 0);
        wait_commit(2);

        // Read sees pre-frame data; write lands only after commit.
        mem_model[16'h2000] = 8'h11;
        access(1, 1, 0, 16'h2000, 8'h11, 0, lat);
        chk("rw_rd_lat", 32'(lat), 3);
        access(0, 0, 1, 16'h2000, 8'h22, 1, lat);
        chk("rw_mem_before", 32'(mem_model[16'h2000]), 32'h11);
        pulse(1, 0);
        wait_commit(3);
        chk("rw_mem_after", 32'(mem_model[16'h2000]), 32'h22);

        // Overflow: 65 writes into a 64-deep buffer, commit suppressed.
        for (int i = 0; i < 65; i++) begin
            access(0, i == 0, i == 64, 16'(16'h3000 + i), 8'(i), 0, lat);
            chk("ovf_lat", 32'(lat), 1);
            if (i == 63) begin
                chk("ovf_before", 32'(wbuf_ovf), 0);
                chk("level_full", 32'(wbuf_level), 64);
            end
        end
        chk("ovf_set", 32'(wbuf_ovf), 1);
        chk("level_sat", 32'(wbuf_level), 64);
        pulse(1, 0);
        repeat (10) @(negedge clk);
        chk("ovf_no_commit", 32'(commit_cnt), 3);
        chk("ovf_no_wr", 32'(wr_seen), 4);
        chk("ovf_level_clr", 32'(wbuf_level), 0);

        // Read of a new frame issued while four writes drain.
        mem_model[16'h0200] = 8'h77;
        for (int i = 0; i < 4; i++) begin
            access(0, i == 0, i == 3, 16'(16'h4000 + i), 8'(8'hC0 + i), 1, lat);
            if (i == 0) chk("ovf_cleared", 32'(wbuf_ovf), 0);
        end
        pulse(1, 0);
        access(1, 1, 1, 16'h0200, 8'h77, 0, lat);
        chk("drain_commit", 32'(commit_cnt), 4);
        chk("drain_wr_count", 32'(wr_seen), 8);
        chk("drain_mem_last", 32'(mem_model[16'h4003]), 32'hC3);
        pulse(1, 0);
        wait_commit(5);
        chk("rsp_queue_empty", 32'(exp_rsp.size()), 0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ecat_fifo_mem_bridge.md
Name: ecat_fifo_mem_bridge

Overview:
Memory-side consumer of the datagram handler's byte FIFO access interface (fifo_sof/eof/valid/read/addr/wdata -> fifo_rdata/ready). It serves read bytes directly from process/register memory. It stages write bytes of the current frame in a local write buffer and commits them to memory only when the datagram handler signals a good frame (FCS ok), or discards them on a bad frame. It sits between the datagram handler and the ESC memory arbiter; the arbiter port is a req/gnt handshake shared with the PDI side.

Parameters:
WBUF_DEPTH, 64, staged write entries per frame (power of 2)
WBUF_AW, 6, log2(WBUF_DEPTH)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
fifo_sof  input  1  first access of a frame, qualified by fifo_valid
fifo_eof  input  1  last access of a frame, qualified by fifo_valid
fifo_valid  input  1  one-cycle access strobe
fifo_read  input  1  1=read byte, 0=write byte
fifo_addr  input  16  physical byte address
fifo_wdata  input  8  write byte
fifo_rdata  output  8  read byte, valid with fifo_ready
fifo_ready  output  1  one-cycle completion pulse per access
frame_ok  input  1  pulse: frame ended with good FCS, commit writes
frame_err  input  1  pulse: frame bad/aborted, discard writes
mem_req  output  1  arbiter request, held until mem_gnt
mem_we  output  1  write qualifier of mem_req
mem_addr  output  16  memory address
mem_wdata  output  8  memory write data
mem_gnt  input  1  arbiter grant, one cycle
mem_rdata  input  8  read data, valid the cycle after mem_gnt
wbuf_level  output  WBUF_AW+1  staged entry count
wbuf_ovf  output  1  sticky overflow for current frame
commit_done  output  1  pulse: drain finished or empty commit

Behaviour:
- Reset: all outputs 0, state IDLE, buffer pointers 0, pending register empty.
- Access protocol: the datagram handler keeps at most one access outstanding and waits for fifo_ready. The bridge latches every fifo_valid into a one-entry pending register, so a strobe arriving in any state is never lost.
- States:
  - IDLE: no frame open. A pending access with sof opens a frame: clear wbuf_ovf and go to ACTIVE. A pending access without sof is serviced the same way, as an implicit open.
  - ACTIVE, write access: if wbuf_level < WBUF_DEPTH, store {addr,data} and increment the level. Otherwise drop the byte and set wbuf_ovf. fifo_ready pulses the cycle after the strobe in both cases.
  - ACTIVE, read access: go to RD. mem_req=1, mem_we=0, mem_addr=fifo_addr starting the cycle after the strobe.
  - RD: hold mem_req until mem_gnt. Go to RD_DATA.
  - RD_DATA: fifo_rdata<=mem_rdata, fifo_ready=1 for one cycle. Return to ACTIVE.
  - Read semantics: reads return memory contents and never forward from the write buffer. A read always sees pre-frame data, which matches EtherCAT RW semantics.
  - After an eof access completes, stay in ACTIVE and wait for frame_ok/frame_err.
  - frame_ok with wbuf_ovf=0 and level>0: go to DRAIN.
  - frame_ok with level=0: commit_done next cycle, go to IDLE.
  - frame_ok with wbuf_ovf=1: treated exactly as frame_err.
  - frame_err: reset pointers and level next cycle, commit_done not asserted, go to IDLE.
  - DRAIN: present the oldest entry with mem_req=1, mem_we=1. On mem_gnt, pop the entry and present the next one the following cycle. When the last entry is granted, pulse commit_done and go to IDLE. A pending access arriving during DRAIN is serviced after DRAIN completes.
- Simultaneous events:
  - frame_ok/frame_err during RD or RD_DATA: latched and acted on after the read completes.
  - frame_ok and frame_err in the same cycle: err wins.
  - frame_ok/err in IDLE: ignored.
- Buffer: circular, write pointer and read pointer each WBUF_AW bits, wrapping modulo WBUF_DEPTH. The level counter is WBUF_AW+1 bits and saturates at WBUF_DEPTH.
- Reset mid-DRAIN or mid-RD: mem_req drops immediately and all staged data is lost.

Decomposition:
- Shared package: state encoding (IDLE, ACTIVE, RD, RD_DATA, DRAIN) and the entry width constant (24 = 16 address + 8 data).
- One natural sub-module: ecat_wbuf_fifo, a synchronous circular buffer with push/pop/level/full/flush.

Test Plan:
- Frame of 3 writes (0x1000=AA, 0x1001=BB, 0x1002=CC), then frame_ok, mem_gnt always 1 -> fifo_ready once per write. Three mem writes in order. commit_done one cycle after the last grant. Final wbuf_level=0.
- Frame of 2 writes, then frame_err -> no mem_req with mem_we=1, wbuf_level returns to 0, no commit_done.
- Read 0x0130 with mem_gnt delayed 5 cycles, mem_rdata=0x5A -> mem_req held 5 cycles. fifo_ready with fifo_rdata=0x5A two cycles after gnt.
- RW sequence: read 0x2000 (mem=0x11), then write 0x2000=0x22, then frame_ok -> read returns 0x11 and memory holds 0x22 after commit_done.
- 65 writes with WBUF_DEPTH=64 -> wbuf_ovf=1 on the 65th write, which still gets fifo_ready. A following frame_ok produces no memory writes and no commit_done.
- A new frame's sof read issued during DRAIN of the previous 4 entries -> all 4 drain writes occur before the read's mem_req, and the read completes normally.
